// File: rtl/uncache_dm_pkg.sv
// rtl/uncache_dm_pkg.sv - state encodings, bus type codes and size decode for uncache_dm
package uncache_dm_pkg;

    localparam logic [2:0] UC_IDLE    = 3'd0;
    localparam logic [2:0] UC_RD_REQ  = 3'd1;
    localparam logic [2:0] UC_RD_WAIT = 3'd2;
    localparam logic [2:0] UC_WR_REQ  = 3'd3;
    localparam logic [2:0] UC_DONE    = 3'd4;

    localparam logic [2:0] TYPE_BYTE = 3'b000;
    localparam logic [2:0] TYPE_HALF = 3'b001;
    localparam logic [2:0] TYPE_WORD = 3'b010;

    // Pipeline size codes collapse onto the three bus transfer sizes.
    function automatic logic [2:0] dmsel_to_type(input logic [2:0] dmsel);
        logic [2:0] t;
        case (dmsel)
            3'b001, 3'b101, 3'b110: t = TYPE_HALF;
            3'b010, 3'b111:         t = TYPE_WORD;
            default:                t = TYPE_BYTE;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/uncache_dm.sv
// rtl/uncache_dm.sv - uncached MEM-stage load/store unit issuing single-beat bus requests
module uncache_dm
    import uncache_dm_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid,
    input  logic        op,
    input  logic [31:0] addr,
    input  logic [2:0]  dmsel,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        rd_req,
    output logic [2:0]  rd_type,
    output logic [31:0] rd_addr,
    input  logic        rd_rdy,
    input  logic        ret_valid,
    input  logic        ret_last,
    input  logic [31:0] ret_data,
    output logic        wr_req,
    output logic [2:0]  wr_type,
    output logic [31:0] wr_addr,
    output logic [3:0]  wr_wstrb,
    output logic [31:0] wr_data,
    input  logic        wr_rdy
);

    logic [2:0]  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  type_q, type_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        type_d  = type_q;
        wstrb_d = wstrb_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            // DONE accepts like IDLE so back-to-back accesses lose no cycle.
            UC_IDLE, UC_DONE: begin
                if (valid) begin
                    addr_d  = addr;
                    type_d  = dmsel_to_type(dmsel);
                    wstrb_d = wstrb;
                    wdata_d = wdata;
                    state_d = op ? UC_WR_REQ : UC_RD_REQ;
                end else begin
                    state_d = UC_IDLE;
                end
            end
            UC_RD_REQ: begin
                if (rd_rdy) begin
                    state_d = UC_RD_WAIT;
                end
            end
            UC_RD_WAIT: begin
                if (ret_valid && ret_last) begin
                    rdata_d = ret_data;
                    state_d = UC_DONE;
                end
            end
            UC_WR_REQ: begin
                if (wr_rdy) begin
                    state_d = UC_DONE;
                end
            end
            default: state_d = UC_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= UC_IDLE;
            addr_q  <= 32'd0;
            type_q  <= 3'd0;
            wstrb_q <= 4'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            type_q  <= type_d;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Outputs depend on registered state only, so valid never reaches data_ok.
    assign data_ok  = (state_q == UC_IDLE) || (state_q == UC_DONE);
    assign rdata    = rdata_q;
    assign rd_req   = (state_q == UC_RD_REQ);
    assign rd_type  = type_q;
    assign rd_addr  = addr_q;
    assign wr_req   = (state_q == UC_WR_REQ);
    assign wr_type  = type_q;
    assign wr_addr  = addr_q;
    assign wr_wstrb = wstrb_q;
    assign wr_data  = wdata_q;

endmodule

// File: tb/tb_uncache_dm.sv
// tb/tb_uncache_dm.sv - self-checking bench for uncache_dm
module tb_uncache_dm;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        valid = 1'b0;
    logic        op = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [2:0]  dmsel = 3'd0;
    logic [3:0]  wstrb = 4'd0;
    logic [31:0] wdata = 32'd0;
    logic        data_ok;
    logic [31:0] rdata;
    logic        rd_req;
    logic [2:0]  rd_type;
    logic [31:0] rd_addr;
    logic        rd_rdy = 1'b0;
    logic        ret_valid = 1'b0;
    logic        ret_last = 1'b0;
    logic [31:0] ret_data = 32'd0;
    logic        wr_req;
    logic [2:0]  wr_type;
    logic [31:0] wr_addr;
    logic [3:0]  wr_wstrb;
    logic [31:0] wr_data;
    logic        wr_rdy = 1'b0;

    int checks = 0;
    int errors = 0;

    uncache_dm dut (
        .clk(clk), .resetn(resetn), .valid(valid), .op(op), .addr(addr),
        .dmsel(dmsel), .wstrb(wstrb), .wdata(wdata), .data_ok(data_ok),
        .rdata(rdata), .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr),
        .rd_rdy(rd_rdy), .ret_valid(ret_valid), .ret_last(ret_last),
        .ret_data(ret_data), .wr_req(wr_req), .wr_type(wr_type),
        .wr_addr(wr_addr), .wr_wstrb(wr_wstrb), .wr_data(wr_data),
        .wr_rdy(wr_rdy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] size_of(input logic [2:0] s);
        if (s == 3'd2 || s == 3'd7) return 3'b010;
        if (s == 3'd1 || s == 3'd5 || s == 3'd6) return 3'b001;
        return 3'b000;
    endfunction

    // Transaction-level model: at most one outstanding access, in a named phase.
    typedef enum int {PH_NONE, PH_RD_ISSUE, PH_RD_DATA, PH_WR_ISSUE} phase_t;
    phase_t      m_phase = PH_NONE;
    logic [31:0] m_addr = 0, m_wdata = 0, m_rdata = 0;
    logic [3:0]  m_strb = 0;
    logic [2:0]  m_size = 0;
    logic        model_on = 1'b0;

    always @(posedge clk) begin
        model_on <= 1'b1;
        if (!resetn) begin
            m_phase <= PH_NONE;
            m_rdata <= 0;
            m_addr <= 0; m_wdata <= 0; m_strb <= 0; m_size <= 0;
        end else if (m_phase == PH_NONE) begin
            if (valid) begin
                m_phase <= op ? PH_WR_ISSUE : PH_RD_ISSUE;
                m_addr <= addr; m_wdata <= wdata; m_strb <= wstrb;
                m_size <= size_of(dmsel);
            end
        end else if (m_phase == PH_RD_ISSUE) begin
            if (rd_rdy) m_phase <= PH_RD_DATA;
        end else if (m_phase == PH_RD_DATA) begin
            if (ret_valid && ret_last) begin
                m_rdata <= ret_data;
                m_phase <= PH_NONE;
            end
        end else if (wr_rdy) begin
            m_phase <= PH_NONE;
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("m_data_ok", {31'd0, data_ok}, {31'd0, m_phase == PH_NONE});
            chk("m_rd_req", {31'd0, rd_req}, {31'd0, m_phase == PH_RD_ISSUE});
            chk("m_wr_req", {31'd0, wr_req}, {31'd0, m_phase == PH_WR_ISSUE});
            chk("m_rdata", rdata, m_rdata);
            if (m_phase == PH_RD_ISSUE) begin
                chk("m_rd_type", {29'd0, rd_type}, {29'd0, m_size});
                chk("m_rd_addr", rd_addr, m_addr);
            end
            if (m_phase == PH_WR_ISSUE) begin
                chk("m_wr_type", {29'd0, wr_type}, {29'd0, m_size});
                chk("m_wr_addr", wr_addr, m_addr);
                chk("m_wr_wstrb", {28'd0, wr_wstrb}, {28'd0, m_strb});
                chk("m_wr_data", wr_data, m_wdata);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic o, input logic [31:0] a, input logic [2:0] s,
                       input logic [3:0] st, input logic [31:0] d);
        valid = 1'b1; op = o; addr = a; dmsel = s; wstrb = st; wdata = d;
    endtask

    initial begin
        step(); step();
        chk("rst_data_ok", {31'd0, data_ok}, 32'd1);
        chk("rst_outs", {rd_req, wr_req, rd_type, wr_type, wr_wstrb}, 32'd0);
        chk("rst_addr_data", rd_addr | wr_addr | wr_data | rdata, 32'd0);
        resetn = 1'b1;
        step();

        // Word load, zero-wait bridge.
        req(1'b0, 32'h1faf_f000, 3'b111, 4'h0, 32'd0);
        step();
        valid = 1'b0; rd_rdy = 1'b1;
        chk("ld_rd_req", {31'd0, rd_req}, 32'd1);
        chk("ld_rd_type", {29'd0, rd_type}, 32'd2);
        chk("ld_rd_addr", rd_addr, 32'h1faf_f000);
        chk("ld_busy1", {31'd0, data_ok}, 32'd0);
        step();
        rd_rdy = 1'b0; ret_valid = 1'b1; ret_last = 1'b1; ret_data = 32'hDEAD_BEEF;
        chk("ld_req_drop", {31'd0, rd_req}, 32'd0);
        chk("ld_busy2", {31'd0, data_ok}, 32'd0);
        step();
        ret_valid = 1'b0; ret_last = 1'b0;
        chk("ld_done", {31'd0, data_ok}, 32'd1);
        chk("ld_rdata", rdata, 32'hDEAD_BEEF);
        // Back-to-back: store presented in the DONE cycle.
        req(1'b1, 32'h1faf_f003, 3'b000, 4'b1000, 32'hAA00_0000);
        step();
        valid = 1'b0;
        chk("b2b_wr_req", {31'd0, wr_req}, 32'd1);
        chk("b2b_busy", {31'd0, data_ok}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("st_wr_req", {31'd0, wr_req}, 32'd1);
            chk("st_fields", {wr_type, wr_wstrb}, {25'd0, 3'b000, 4'b1000});
            chk("st_addr", wr_addr, 32'h1faf_f003);
            chk("st_data", wr_data, 32'hAA00_0000);
            step();
        end
        wr_rdy = 1'b1;
        chk("st_wr_req4", {31'd0, wr_req}, 32'd1);
        chk("st_addr4", wr_addr, 32'h1faf_f003);
        step();
        wr_rdy = 1'b0;
        chk("st_done", {31'd0, data_ok}, 32'd1);
        chk("st_req_drop", {31'd0, wr_req}, 32'd0);
        chk("st_keeps_rdata", rdata, 32'hDEAD_BEEF);
        step();
        chk("st_idle", {31'd0, data_ok}, 32'd1);

        // Half load with late return, plus valid toggling while busy.
        req(1'b0, 32'h1faf_f102, 3'b101, 4'h0, 32'd0);
        step();
        valid = 1'b0; rd_rdy = 1'b1;
        chk("hl_rd_type", {29'd0, rd_type}, 32'd1);
        step();
        rd_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            valid = i[0] ? 1'b0 : 1'b1;
            op = 1'b1; addr = 32'h0bad_0000 + i;
            ret_valid = (i == 2); ret_last = 1'b0; ret_data = 32'h5555_5555;
            chk("hl_busy", {31'd0, data_ok}, 32'd0);
            chk("hl_rdata_old", rdata, 32'hDEAD_BEEF);
            chk("hl_addr_held", rd_addr, 32'h1faf_f102);
            step();
        end
        valid = 1'b0; ret_valid = 1'b1; ret_last = 1'b1; ret_data = 32'h1234_5678;
        chk("hl_busy_last", {31'd0, data_ok}, 32'd0);
        step();
        ret_valid = 1'b0; ret_last = 1'b0;
        chk("hl_done", {31'd0, data_ok}, 32'd1);
        chk("hl_rdata", rdata, 32'h1234_5678);
        chk("hl_no_wr", {31'd0, wr_req}, 32'd0);
        step();

        // rd_rdy and ret_valid together in RD_REQ, then reset in RD_WAIT.
        req(1'b0, 32'h1faf_f200, 3'b010, 4'h0, 32'd0);
        step();
        valid = 1'b0; rd_rdy = 1'b1; ret_valid = 1'b1; ret_last = 1'b1; ret_data = 32'hCAFE_F00D;
        step();
        rd_rdy = 1'b0; ret_valid = 1'b0; ret_last = 1'b0;
        chk("early_ret_busy", {31'd0, data_ok}, 32'd0);
        chk("early_ret_rdata", rdata, 32'h1234_5678);
        resetn = 1'b0;
        step();
        resetn = 1'b1; ret_valid = 1'b1; ret_last = 1'b1; ret_data = 32'h7777_7777;
        chk("rst_mid_ok", {31'd0, data_ok}, 32'd1);
        chk("rst_mid_req", {30'd0, rd_req, wr_req}, 32'd0);
        chk("rst_mid_rdata", rdata, 32'd0);
        step();
        ret_valid = 1'b0; ret_last = 1'b0;
        chk("rst_late_ret", rdata, 32'd0);
        chk("rst_late_ok", {31'd0, data_ok}, 32'd1);
        step(); step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
